// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side handshake signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch stage (read-only requester)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Access stage (loads and stores)
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [3:0]        dm_wstrb;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // Unified memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  // Environment view (pipeline stages plus memory model)
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access: data-first priority,
// bounded by a starvation counter so a waiting fetch always gets through.
// One outstanding transaction at a time; all outputs registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;

  // State and output registers; reset abandons any outstanding command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Arbitration, command load and completion handling
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.dm_req && (!bus.if_req || (starve_q < STARVE_LIM))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_wstrb_d = bus.dm_wstrb;
          dm_gnt_d    = 1'b1;
          // Count only grants that made a fetch wait
          if (!bus.if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (bus.if_req) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          if_gnt_d    = 1'b1;
          starve_d    = '0;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rdata_d  = bus.mem_rdata;
          if_rvalid_d = 1'b1;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ack) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          dm_rdata_d  = bus.mem_rdata;
          dm_rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Drive registered values onto the bus
  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for fetch, collision and
// store traffic, then hand sequences for starvation, back-to-back fetch and reset.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic        O  = 1'b0;
  localparam logic        I  = 1'b1;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [3:0]  Z4 = 4'h0;

  // Inputs applied for one cycle, then outputs expected after the edge
  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [31:0] da; logic [31:0] dd; logic [3:0] ds;
    logic        ack; logic [31:0] mrd;
    logic        ig;  logic iv; logic [31:0] ird;
    logic        dg;  logic dv; logic [31:0] drd; logic dchk;
    logic        mr;  logic mw; logic [31:0] ma; logic [31:0] md; logic [3:0] ms;
    logic        bz;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds,
                       input logic ack, input logic [31:0] mrd);
    bus.if_req    = ir;
    bus.if_addr   = ia;
    bus.dm_req    = dr;
    bus.dm_we     = dw;
    bus.dm_addr   = da;
    bus.dm_wdata  = dd;
    bus.dm_wstrb  = ds;
    bus.mem_ack   = ack;
    bus.mem_rdata = mrd;
  endtask

  initial begin
    // Single fetch, ack two cycles after mem_req
    vt[0]  = '{I,32'h100,O,O,Z,Z,Z4,O,Z,           I,O,Z,        O,O,Z,I,            I,O,32'h100,Z,Z4,I};
    vt[1]  = '{I,32'h100,O,O,Z,Z,Z4,O,Z,           O,O,Z,        O,O,Z,I,            I,O,32'h100,Z,Z4,I};
    vt[2]  = '{O,32'h1FC,O,O,Z,Z,Z4,O,Z,           O,O,Z,        O,O,Z,I,            I,O,32'h100,Z,Z4,I};
    vt[3]  = '{O,Z,O,O,Z,Z,Z4,I,32'h13,            O,I,32'h13,   O,O,Z,I,            O,O,Z,Z,Z4,O};
    vt[4]  = '{O,Z,O,O,Z,Z,Z4,O,Z,                 O,O,32'h13,   O,O,Z,I,            O,O,Z,Z,Z4,O};
    // Collision, zero-wait: data first, fetch at the next arbitration
    vt[5]  = '{I,32'h104,I,O,32'h2000,Z,Z4,O,Z,    O,O,32'h13,   I,O,Z,I,            I,O,32'h2000,Z,Z4,I};
    vt[6]  = '{I,32'h104,I,O,32'h2000,Z,Z4,I,32'hCAFE0001, O,O,32'h13, O,I,32'hCAFE0001,I, O,O,Z,Z,Z4,O};
    vt[7]  = '{I,32'h104,O,O,Z,Z,Z4,O,Z,           I,O,32'h13,   O,O,32'hCAFE0001,I, I,O,32'h104,Z,Z4,I};
    vt[8]  = '{I,32'h104,O,O,Z,Z,Z4,I,32'h93,      O,I,32'h93,   O,O,32'hCAFE0001,I, O,O,Z,Z,Z4,O};
    vt[9]  = '{O,Z,O,O,Z,Z,Z4,O,Z,                 O,O,32'h93,   O,O,32'hCAFE0001,I, O,O,Z,Z,Z4,O};
    // Store with three wait cycles; command must hold while requester fields change
    vt[10] = '{O,Z,I,I,32'h3004,32'hDEADBEEF,4'h3,O,Z, O,O,32'h93, I,O,32'hCAFE0001,I, I,I,32'h3004,32'hDEADBEEF,4'h3,I};
    vt[11] = '{O,Z,I,I,32'h3004,32'hDEADBEEF,4'h3,O,Z, O,O,32'h93, O,O,32'hCAFE0001,I, I,I,32'h3004,32'hDEADBEEF,4'h3,I};
    vt[12] = '{O,Z,O,O,32'hFFFF,Z,Z4,O,Z,          O,O,32'h93,   O,O,32'hCAFE0001,I, I,I,32'h3004,32'hDEADBEEF,4'h3,I};
    vt[13] = '{O,Z,O,O,32'hFFFF,Z,Z4,O,32'h77,     O,O,32'h93,   O,O,32'hCAFE0001,I, I,I,32'h3004,32'hDEADBEEF,4'h3,I};
    vt[14] = '{O,Z,O,O,Z,Z,Z4,I,32'h55AA55AA,      O,O,32'h93,   O,I,Z,O,            O,O,Z,Z,Z4,O};
    vt[15] = '{O,Z,O,O,Z,Z,Z4,O,Z,                 O,O,32'h93,   O,O,Z,O,            O,O,Z,Z,Z4,O};

    // Reset state
    rst = 1'b0;
    drive(O, Z, O, O, Z, Z, Z4, O, Z);
    repeat (2) @(posedge clk);
    #1;
    chk("rst if_gnt",    32'(bus.if_gnt),    Z);
    chk("rst dm_gnt",    32'(bus.dm_gnt),    Z);
    chk("rst if_rvalid", 32'(bus.if_rvalid), Z);
    chk("rst dm_rvalid", 32'(bus.dm_rvalid), Z);
    chk("rst mem_req",   32'(bus.mem_req),   Z);
    chk("rst mem_addr",  bus.mem_addr,       Z);
    chk("rst if_rdata",  bus.if_rdata,       Z);
    chk("rst dm_rdata",  bus.dm_rdata,       Z);
    chk("rst busy",      32'(busy),          Z);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven cycles
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dd, vt[i].ds,
            vt[i].ack, vt[i].mrd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d if_gnt", i),    32'(bus.if_gnt),    32'(vt[i].ig));
      chk($sformatf("v%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(vt[i].iv));
      chk($sformatf("v%0d if_rdata", i),  bus.if_rdata,       vt[i].ird);
      chk($sformatf("v%0d dm_gnt", i),    32'(bus.dm_gnt),    32'(vt[i].dg));
      chk($sformatf("v%0d dm_rvalid", i), 32'(bus.dm_rvalid), 32'(vt[i].dv));
      if (vt[i].dchk)
        chk($sformatf("v%0d dm_rdata", i), bus.dm_rdata, vt[i].drd);
      chk($sformatf("v%0d mem_req", i),   32'(bus.mem_req),   32'(vt[i].mr));
      chk($sformatf("v%0d busy", i),      32'(busy),          32'(vt[i].bz));
      if (vt[i].mr) begin
        chk($sformatf("v%0d mem_we", i),    32'(bus.mem_we),    32'(vt[i].mw));
        chk($sformatf("v%0d mem_addr", i),  bus.mem_addr,       vt[i].ma);
        chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata,      vt[i].md);
        chk($sformatf("v%0d mem_wstrb", i), 32'(bus.mem_wstrb), 32'(vt[i].ms));
      end
    end

    // Starvation: both requesting continuously, zero-wait memory
    drive(I, 32'h200, I, O, 32'h4000, Z, Z4, I, Z);
    for (int t = 0; t < 10; t++) begin
      bit exp_dm;
      exp_dm = ((t % 5) != 4);
      bus.mem_rdata = 32'hA000 + 32'(t);
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d dm_gnt", t), 32'(bus.dm_gnt), 32'(exp_dm));
      chk($sformatf("starve%0d if_gnt", t), 32'(bus.if_gnt), 32'(!exp_dm));
      chk($sformatf("starve%0d mem_addr", t), bus.mem_addr, exp_dm ? 32'h4000 : 32'h200);
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d dm_rvalid", t), 32'(bus.dm_rvalid), 32'(exp_dm));
      chk($sformatf("starve%0d if_rvalid", t), 32'(bus.if_rvalid), 32'(!exp_dm));
      if (exp_dm)
        chk($sformatf("starve%0d dm_rdata", t), bus.dm_rdata, 32'hA000 + 32'(t));
      else
        chk($sformatf("starve%0d if_rdata", t), bus.if_rdata, 32'hA000 + 32'(t));
    end

    // Back-to-back fetches: one transaction every two cycles
    drive(I, 32'h300, O, O, Z, Z, Z4, I, Z);
    for (int k = 0; k < 6; k++) begin
      bus.mem_rdata = 32'hB000 + 32'(k);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d if_gnt", k),   32'(bus.if_gnt),  32'd1);
      chk($sformatf("b2b%0d dm_gnt", k),   32'(bus.dm_gnt),  32'd0);
      chk($sformatf("b2b%0d mem_addr", k), bus.mem_addr,     32'h300);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d if_rvalid", k), 32'(bus.if_rvalid), 32'd1);
      chk($sformatf("b2b%0d if_rdata", k),  bus.if_rdata,       32'hB000 + 32'(k));
      chk($sformatf("b2b%0d busy", k),      32'(busy),          32'd0);
    end
    // Starvation count stayed clear: data still beats a waiting fetch
    drive(I, 32'h300, I, O, 32'h6000, Z, Z4, I, Z);
    @(posedge clk);
    #1;
    chk("b2b post dm_gnt", 32'(bus.dm_gnt), 32'd1);
    drive(O, Z, O, O, Z, Z, Z4, I, Z);
    @(posedge clk);
    #1;
    chk("b2b post dm_rvalid", 32'(bus.dm_rvalid), 32'd1);

    // Reset in the middle of a data transaction
    drive(O, Z, I, O, 32'h5000, Z, Z4, O, 32'h1234);
    @(posedge clk);
    #1;
    chk("mid dm_gnt",  32'(bus.dm_gnt),  32'd1);
    chk("mid mem_req", 32'(bus.mem_req), 32'd1);
    bus.dm_req = 1'b0;
    @(posedge clk);
    #1;
    chk("mid busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst mem_req",   32'(bus.mem_req),   Z);
    chk("arst busy",      32'(busy),          Z);
    chk("arst dm_gnt",    32'(bus.dm_gnt),    Z);
    chk("arst dm_rvalid", 32'(bus.dm_rvalid), Z);
    chk("arst if_rvalid", 32'(bus.if_rvalid), Z);
    chk("arst mem_addr",  bus.mem_addr,       Z);
    chk("arst dm_rdata",  bus.dm_rdata,       Z);
    chk("arst if_rdata",  bus.if_rdata,       Z);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post%0d dm_rvalid", c), 32'(bus.dm_rvalid), Z);
      chk($sformatf("post%0d if_rvalid", c), 32'(bus.if_rvalid), Z);
      chk($sformatf("post%0d mem_req", c),   32'(bus.mem_req),   Z);
      chk($sformatf("post%0d busy", c),      32'(busy),          Z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
